// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - VGA timing, framebuffer geometry and scanout pipeline types
package gpu_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_SYNC_START = H_ACTIVE + H_FP;        // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;  // 752
  localparam int H_TOTAL      = H_SYNC_END + H_BP;      // 800

  localparam int V_ACTIVE     = 400;
  localparam int V_FP         = 12;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 35;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;        // 412
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;  // 414
  localparam int V_TOTAL      = V_SYNC_END + V_BP;      // 449

  localparam logic HS_ACTIVE = 1'b1;
  localparam logic VS_ACTIVE = 1'b0;

  localparam int FB_WIDTH          = 320;
  localparam int FB_HEIGHT         = 200;
  localparam int FB_BYTES          = 8000;
  localparam int FB_BYTES_PER_LINE = 40;
  localparam int ADDR_W            = 13;
  localparam int CNT_W             = 10;
  localparam int SCANOUT_LAT       = 3;

  typedef struct packed {
    logic       active;
    logic       fetch;
    logic [2:0] bit_idx;
    logic       hs;
    logic       vs;
  } scan_stage_t;

  localparam scan_stage_t STAGE_RESET = '{
    active: 1'b0, fetch: 1'b0, bit_idx: 3'd0, hs: ~HS_ACTIVE, vs: ~VS_ACTIVE
  };

  // Bit 0 of a framebuffer byte is the leftmost pixel on screen.
  function automatic logic pixel_bit(input logic [7:0] b, input logic [2:0] idx);
    return b[idx];
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - framebuffer synchronous read port
interface vga_scanout_if;
  import gpu_pkg::*;

  logic              fb_rd_en;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [7:0]        fb_rd_data;

  modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
  modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - h/v counters, raw sync decode, registered vblank and frame_start
module vga_timing
  import gpu_pkg::*;
#(
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic [CNT_W-1:0] h_o,
  output logic [CNT_W-1:0] v_o,
  output logic             line_end_o,
  output logic             frame_end_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             vblank_o,
  output logic             frame_start_o
);
  localparam int VS_START = V_ACT + V_FRONT;
  localparam int VS_END   = VS_START + V_PULSE;
  localparam int V_TOT    = VS_END + V_BACK;

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             vblank_q, vblank_d, fs_q, fs_d;

  always_comb begin
    line_end_o  = (h_q == CNT_W'(H_TOTAL - 1));
    frame_end_o = line_end_o && (v_q == CNT_W'(V_TOT - 1));
    h_d = line_end_o ? '0 : h_q + 1'b1;
    v_d = v_q;
    if (frame_end_o)     v_d = '0;
    else if (line_end_o) v_d = v_q + 1'b1;
    vblank_d = (v_q >= CNT_W'(V_ACT));
    fs_d     = (h_q == '0) && (v_q == '0);
    hsync_o  = (h_q >= CNT_W'(H_SYNC_START) && h_q < CNT_W'(H_SYNC_END)) ? HS_ACTIVE : ~HS_ACTIVE;
    vsync_o  = (v_q >= CNT_W'(VS_START) && v_q < CNT_W'(VS_END)) ? VS_ACTIVE : ~VS_ACTIVE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      h_q      <= '0;
      v_q      <= '0;
      vblank_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      vblank_q <= vblank_d;
      fs_q     <= fs_d;
    end
  end

  assign h_o           = h_q;
  assign v_o           = v_q;
  assign vblank_o      = vblank_q;
  assign frame_start_o = fs_q;
endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - 320x200 1bpp framebuffer scanout to 640x400 VGA, pixels doubled
module vga_scanout
  import gpu_pkg::*;
#(
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP
) (
  input  logic                 vga_clk,
  input  logic                 rst_n,
  vga_scanout_if.master        fb,
  input  logic [7:0]           fg_color,
  input  logic [7:0]           bg_color,
  output logic                 hsync,
  output logic                 vsync,
  output logic [7:0]           rgb,
  output logic                 vblank,
  output logic                 frame_start
);
  logic [CNT_W-1:0]  h, v;
  logic              line_end, frame_end, hs_raw, vs_raw, active0;
  logic [ADDR_W-1:0] line_base_q, line_base_d, addr_q, addr_d;
  scan_stage_t       s1_q, s1_d, s2_q;
  logic [7:0]        pix_q, pix_d, rgb_q, rgb_d, fg_q, bg_q;
  logic              hsync_q, vsync_q;

  vga_timing #(
    .V_ACT(V_ACT), .V_FRONT(V_FRONT), .V_PULSE(V_PULSE), .V_BACK(V_BACK)
  ) u_timing (
    .clk_i        (vga_clk),
    .rst_ni       (rst_n),
    .h_o          (h),
    .v_o          (v),
    .line_end_o   (line_end),
    .frame_end_o  (frame_end),
    .hsync_o      (hs_raw),
    .vsync_o      (vs_raw),
    .vblank_o     (vblank),
    .frame_start_o(frame_start)
  );

  always_comb begin
    // Each framebuffer row is shown twice, so the base only advances after odd lines.
    line_base_d = line_base_q;
    if (frame_end)
      line_base_d = '0;
    else if (line_end && v[0] && v < CNT_W'(V_ACT))
      line_base_d = line_base_q + ADDR_W'(FB_BYTES_PER_LINE);

    active0        = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACT));
    s1_d.active    = active0;
    s1_d.fetch     = active0 && (h[3:0] == 4'd0);
    s1_d.bit_idx   = h[3:1];
    s1_d.hs        = hs_raw;
    s1_d.vs        = vs_raw;
    addr_d = s1_d.fetch ? line_base_q + ADDR_W'(h[CNT_W-1:4]) : addr_q;

    // Read data is used in its arrival cycle; outside it the bus is never looked at.
    pix_d = s2_q.fetch ? fb.fb_rd_data : pix_q;
    rgb_d = '0;
    if (s2_q.active)
      rgb_d = pixel_bit(pix_d, s2_q.bit_idx) ? fg_q : bg_q;
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      line_base_q <= '0;
      addr_q      <= '0;
      s1_q        <= STAGE_RESET;
      s2_q        <= STAGE_RESET;
      pix_q       <= '0;
      rgb_q       <= '0;
      hsync_q     <= ~HS_ACTIVE;
      vsync_q     <= ~VS_ACTIVE;
      fg_q        <= '0;
      bg_q        <= '0;
    end else begin
      line_base_q <= line_base_d;
      addr_q      <= addr_d;
      s1_q        <= s1_d;
      s2_q        <= s1_q;
      pix_q       <= pix_d;
      rgb_q       <= rgb_d;
      hsync_q     <= s2_q.hs;
      vsync_q     <= s2_q.vs;
      if (h == '0 && v == '0) begin
        fg_q <= fg_color;
        bg_q <= bg_color;
      end
    end
  end

  assign fb.fb_rd_en   = s1_q.fetch;
  assign fb.fb_rd_addr = addr_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign rgb           = rgb_q;
endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench for vga_scanout with a shortened vertical frame
module tb_vga_scanout;
  import gpu_pkg::*;

  localparam int TB_VACT  = 6;
  localparam int TB_VFP   = 2;
  localparam int TB_VSYNC = 2;
  localparam int TB_VBP   = 2;
  localparam int TB_VTOT  = TB_VACT + TB_VFP + TB_VSYNC + TB_VBP;  // 12 lines
  localparam int FRAME    = TB_VTOT * 800;                         // 9600 cycles

  logic       vga_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] fg_color, bg_color;
  logic       hsync, vsync, vblank, frame_start;
  logic [7:0] rgb;
  logic [7:0] mem [0:8191];

  vga_scanout_if fb_if ();

  vga_scanout #(
    .V_ACT(TB_VACT), .V_FRONT(TB_VFP), .V_PULSE(TB_VSYNC), .V_BACK(TB_VBP)
  ) dut (
    .vga_clk    (vga_clk),
    .rst_n      (rst_n),
    .fb         (fb_if.master),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .hsync      (hsync),
    .vsync      (vsync),
    .rgb        (rgb),
    .vblank     (vblank),
    .frame_start(frame_start)
  );

  always #20 vga_clk = ~vga_clk;

  // Synchronous RAM: data one cycle after the strobe, garbage otherwise.
  always @(posedge vga_clk) begin
    if (fb_if.fb_rd_en === 1'b1) fb_if.fb_rd_data <= mem[fb_if.fb_rd_addr];
    else                         fb_if.fb_rd_data <= 8'hxx;
  end

  int errors = 0;
  int checks = 0;
  int fetch_bad = 0, rgb_bad = 0, hs_bad = 0, vs_bad = 0, fs_bad = 0, vb_bad = 0;
  int req_count = 0;
  int p, h1, v1, h3, v3;
  logic e_en, e_fs, e_vb, e_hs, e_vs;
  logic [12:0] e_addr;
  logic [7:0]  e_rgb, b;
  logic [7:0]  fg_f [0:2];
  logic [7:0]  bg_f [0:2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    mem[0]  = 8'h01;
    mem[1]  = 8'h80;
    mem[80] = 8'h01;
    fg_color = 8'hFF;
    bg_color = 8'h00;
    e_addr = '0;
    repeat (3) @(posedge vga_clk);
    #1 rst_n = 1'b1;
    @(negedge vga_clk);

    for (int c = 0; c <= 2 * FRAME + 3 * 800 + 5 * 800 + 700; c++) begin
      if (c > 0) @(negedge vga_clk);
      if (c % FRAME == 0) begin
        fg_f[c / FRAME] = fg_color;
        bg_f[c / FRAME] = bg_color;
      end

      p = c - 1;
      if (p >= 0) begin
        h1 = p % 800; v1 = (p / 800) % TB_VTOT;
        e_en = (h1 < 640) && (v1 < TB_VACT) && (h1 % 16 == 0);
        e_fs = (h1 == 0) && (v1 == 0);
        e_vb = (v1 >= TB_VACT);
        if (e_en) e_addr = 13'((v1 / 2) * 40 + h1 / 16);
      end else begin
        e_en = 1'b0; e_fs = 1'b0; e_vb = 1'b0;
      end
      if (fb_if.fb_rd_en !== e_en || fb_if.fb_rd_addr !== e_addr) fetch_bad++;
      if (frame_start !== e_fs) fs_bad++;
      if (vblank !== e_vb) vb_bad++;
      if (fb_if.fb_rd_en === 1'b1 && c >= 1 && c <= FRAME) req_count++;

      p = c - SCANOUT_LAT;
      e_rgb = 8'h00; e_hs = 1'b0; e_vs = 1'b1;
      if (p >= 0) begin
        h3 = p % 800; v3 = (p / 800) % TB_VTOT;
        e_hs = (h3 >= 656) && (h3 < 752);
        e_vs = !((v3 >= TB_VACT + TB_VFP) && (v3 < TB_VACT + TB_VFP + TB_VSYNC));
        if (h3 < 640 && v3 < TB_VACT) begin
          b = mem[(v3 / 2) * 40 + h3 / 16];
          e_rgb = b[(h3 / 2) % 8] ? fg_f[p / FRAME] : bg_f[p / FRAME];
        end
      end
      if (rgb !== e_rgb) rgb_bad++;
      if (hsync !== e_hs) hs_bad++;
      if (vsync !== e_vs) vs_bad++;

      case (c)
        0: begin
          check("c0_en", fb_if.fb_rd_en, 1'b0);
          check("c0_hsync", hsync, 1'b0);
          check("c0_vsync", vsync, 1'b1);
          check("c0_rgb", rgb, 8'h00);
          check("c0_frame_start", frame_start, 1'b0);
        end
        1: begin
          check("c1_en", fb_if.fb_rd_en, 1'b1);
          check("c1_addr", fb_if.fb_rd_addr, 13'd0);
          check("c1_frame_start", frame_start, 1'b1);
        end
        2: begin
          check("c2_hsync", hsync, 1'b0);
          check("c2_vsync", vsync, 1'b1);
          check("c2_rgb", rgb, 8'h00);
          check("c2_addr_hold", fb_if.fb_rd_addr, 13'd0);
        end
        3:     check("c3_rgb", rgb, 8'hFF);
        4:     check("c4_rgb", rgb, 8'hFF);
        5:     check("c5_rgb", rgb, 8'h00);
        18:    check("c18_rgb", rgb, 8'h00);
        19:    check("c19_rgb", rgb, 8'h00);
        32:    check("c32_rgb", rgb, 8'h00);
        33:    check("c33_rgb", rgb, 8'hFF);
        34:    check("c34_rgb", rgb, 8'hFF);
        658:   check("c658_hsync", hsync, 1'b0);
        659:   check("c659_hsync", hsync, 1'b1);
        754:   check("c754_hsync", hsync, 1'b1);
        755:   check("c755_hsync", hsync, 1'b0);
        801:   check("v1_addr", fb_if.fb_rd_addr, 13'd0);
        1601:  check("v2_addr", fb_if.fb_rd_addr, 13'd40);
        3203:  check("old_fg_after_change", rgb, 8'hFF);
        4625: begin
          check("last_req_en", fb_if.fb_rd_en, 1'b1);
          check("last_req_addr", fb_if.fb_rd_addr, 13'd119);
        end
        4800:  check("c4800_vblank", vblank, 1'b0);
        4801:  check("c4801_vblank", vblank, 1'b1);
        6402:  check("c6402_vsync", vsync, 1'b1);
        6403:  check("c6403_vsync", vsync, 1'b0);
        8002:  check("c8002_vsync", vsync, 1'b0);
        8003:  check("c8003_vsync", vsync, 1'b1);
        9601:  check("frame2_start", frame_start, 1'b1);
        9603:  check("new_fg", rgb, 8'h0F);
        9605:  check("new_bg", rgb, 8'h5A);
        default: ;
      endcase

      if (c == 3 * 800) begin
        fg_color = 8'h0F;
        bg_color = 8'h5A;
      end
    end

    check("requests_per_frame", req_count, 240);
    check("fetch_sweep_bad", fetch_bad, 0);
    check("rgb_sweep_bad", rgb_bad, 0);
    check("hsync_sweep_bad", hs_bad, 0);
    check("vsync_sweep_bad", vs_bad, 0);
    check("frame_start_sweep_bad", fs_bad, 0);
    check("vblank_sweep_bad", vb_bad, 0);
    check("pre_reset_hsync", hsync, 1'b1);
    check("pre_reset_vsync", vsync, 1'b0);
    check("pre_reset_vblank", vblank, 1'b1);

    // Pulse reset for one edge in the middle of the vsync/hsync window.
    rst_n = 1'b0;
    @(negedge vga_clk);
    check("rst_en", fb_if.fb_rd_en, 1'b0);
    check("rst_addr", fb_if.fb_rd_addr, 13'd0);
    check("rst_rgb", rgb, 8'h00);
    check("rst_hsync", hsync, 1'b0);
    check("rst_vsync", vsync, 1'b1);
    check("rst_vblank", vblank, 1'b0);
    check("rst_frame_start", frame_start, 1'b0);
    rst_n = 1'b1;
    @(negedge vga_clk);
    check("rel_c1_en", fb_if.fb_rd_en, 1'b1);
    check("rel_c1_addr", fb_if.fb_rd_addr, 13'd0);
    check("rel_c1_frame_start", frame_start, 1'b1);
    check("rel_c1_hsync", hsync, 1'b0);
    check("rel_c1_vsync", vsync, 1'b1);
    @(negedge vga_clk);
    @(negedge vga_clk);
    check("rel_c3_rgb", rgb, 8'h0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
